// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with saturating stall counter
// Optional stall watchdog enabled by defining STALL_WDT_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          WDT_LIMIT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt,
  output logic        wdt_fire
);

  localparam logic [31:0] EXC_ERET   = 32'h0000000e;
  localparam logic [2:0]  HOLD_LAST  = 3'(FLUSH_CYCLES - 1);
  localparam bit          MULTI_HOLD = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  hold_cnt;
  logic [31:0] held_pc;

  logic        req_any;
  logic [5:0]  req_stall;
  logic        exc_take;
  logic        wdt_trip;
  logic        flush_start;
  logic [31:0] entry_pc;

  assign req_any = stallreq_from_if | stallreq_from_id |
                   stallreq_from_ex | stallreq_from_mem;

  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_from_mem)     req_stall = 6'b011111;
    else if (stallreq_from_ex) req_stall = 6'b001111;
    else if (stallreq_from_id) req_stall = 6'b000111;
    else if (stallreq_from_if) req_stall = 6'b000011;
  end

  // Exceptions arriving while already flushing are dropped: MEM is being cleared anyway.
  assign exc_take = !rst && (state != S_FLUSH) && (excepttype_i != 32'h0);

`ifdef STALL_WDT_EN
  logic [15:0] wdt_cnt;

  assign wdt_trip = !rst && (state != S_FLUSH) && !exc_take && req_any &&
                    (wdt_cnt == 16'(WDT_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || flush || (stall == 6'b000000)) begin
      wdt_cnt <= 16'h0000;
    end else begin
      wdt_cnt <= wdt_cnt + 16'h0001;
    end
  end
`else
  assign wdt_trip = 1'b0;
`endif

  assign flush_start = exc_take | wdt_trip;
  assign flush       = !rst && ((state == S_FLUSH) || flush_start);
  assign stall       = (rst || flush) ? 6'b000000 : req_stall;
  assign wdt_fire    = wdt_trip;

  always_comb begin
    entry_pc = EXC_VECTOR;
    if (!wdt_trip) begin
      case (excepttype_i)
        EXC_ERET:     entry_pc = cp0_epc_i;
        32'h00000001,
        32'h00000008,
        32'h0000000a,
        32'h0000000c,
        32'h0000000d: entry_pc = EXC_VECTOR;
        default:      entry_pc = EXC_VECTOR;
      endcase
    end
  end

  always_comb begin
    new_pc = 32'h0;
    if (!rst) begin
      if (state == S_FLUSH)  new_pc = held_pc;
      else if (flush_start)  new_pc = entry_pc;
    end
  end

  // hold_cnt counts flush cycles already spent, the entry cycle included.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      hold_cnt  <= 3'd0;
      held_pc   <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if ((stall != 6'b000000) && (stall_cnt != 32'hFFFFFFFF)) begin
        stall_cnt <= stall_cnt + 32'h1;
      end
      case (state)
        S_RUN, S_STALL: begin
          if (flush_start) begin
            held_pc  <= entry_pc;
            hold_cnt <= 3'd1;
            state    <= MULTI_HOLD ? S_FLUSH : S_RUN;
          end else begin
            hold_cnt <= 3'd0;
            state    <= req_any ? S_STALL : S_RUN;
          end
        end
        S_FLUSH: begin
          if (hold_cnt >= HOLD_LAST) begin
            hold_cnt <= 3'd0;
            state    <= S_RUN;
          end else begin
            hold_cnt <= hold_cnt + 3'd1;
          end
        end
        default: begin
          hold_cnt <= 3'd0;
          state    <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline (pc, if/id, id/ex, ex/mem, mem/wb).
- Merges stall requests from the IF, ID, EX and MEM stages into the 6-bit `stall` vector consumed by every pipeline register.
- On an exception, redirects fetch through `flush`/`new_pc`.
- Keeps a saturating stall-cycle counter and a flush-hold state machine.

Parameters:
- EXC_VECTOR, 32'h00000020, PC loaded for all non-eret exceptions.
- FLUSH_CYCLES, 1, cycles flush stays asserted per exception (1..7).
- WDT_LIMIT, 255, consecutive stall cycles before watchdog fires (only with STALL_WDT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
- stallreq_from_if  in  1  instruction bus wait.
- stallreq_from_id  in  1  load-use hazard.
- stallreq_from_ex  in  1  multicycle div/madd busy.
- stallreq_from_mem  in  1  data bus wait.
- excepttype_i  in  32  exception code from MEM stage (0 = none).
- cp0_epc_i  in  32  EPC value for eret.
- stall  out  6  bit0 pc, 1 if/id, 2 id/ex, 3 ex/mem, 4 mem/wb, 5 wb; 1 = Stop.
- flush  out  1  clear all pipeline registers, load new_pc.
- new_pc  out  32  redirect target, valid while flush=1.
- stall_cnt  out  32  total stalled cycles since reset, saturating.
- wdt_fire  out  1  one-cycle pulse on watchdog timeout (0 when feature compiled out).

Behaviour:
- Reset (rst=1 at a posedge):
  - FSM goes to S_RUN; stall_cnt=0; hold counter=0; watchdog counter=0.
  - While rst=1, stall=6'b000000, flush=0, new_pc=0, wdt_fire=0.
- stall is combinational from the requests plus FSM state. Priority, highest first:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- Stall requests are ignored (stall=0) whenever flush=1.
- FSM states: S_RUN, S_STALL, S_FLUSH.
  - S_RUN: excepttype_i≠0 → S_FLUSH. Else any stall request → S_STALL. Else stay.
  - S_STALL: excepttype_i≠0 → S_FLUSH. Else no request → S_RUN. Else stay.
  - S_FLUSH: stay until the hold counter reaches FLUSH_CYCLES-1, then → S_RUN. Requests during S_FLUSH are ignored.
- flush timing:
  - Asserted combinationally in the same cycle excepttype_i≠0 is seen (from S_RUN or S_STALL).
  - Stays asserted for every cycle in S_FLUSH.
  - Total high cycles = FLUSH_CYCLES.
  - With FLUSH_CYCLES=1, S_FLUSH lasts zero cycles: the FSM returns to S_RUN on the next edge.
- new_pc:
  - excepttype_i=32'h0000000e (eret) → cp0_epc_i.
  - 32'h00000001/08/0a/0c/0d → EXC_VECTOR.
  - Any other nonzero value → EXC_VECTOR.
  - Captured into a register at entry to S_FLUSH and held constant for the remaining flush cycles.
- A new exception while in S_FLUSH is ignored; MEM is already cleared by flush.
- stall_cnt:
  - Increments on each posedge where stall≠0 and rst=0.
  - Saturates at 32'hFFFFFFFF; no wrap.
- Simultaneous events:
  - Exception plus any stall request in one cycle → flush wins, stall=0, stall_cnt unchanged.
- Reset mid-flush or mid-stall: next edge returns to S_RUN, all counters cleared, no residual flush.

Optional Feature:
Macro STALL_WDT_EN.
- Defined:
  - A 16-bit counter tracks consecutive cycles with stall≠0.
  - It clears when stall=0 or flush=1.
  - When it reaches WDT_LIMIT, wdt_fire pulses for 1 cycle.
  - In that same cycle, flush is forced with new_pc=EXC_VECTOR and the FSM enters S_FLUSH. This is treated as an exception, so stall is forced to 0.
  - The counter then clears.
- Not defined: no counter logic; wdt_fire tied 0; a stall may persist indefinitely.

Test Plan:
1. Reset: rst=1 for 2 cycles with all requests=1, excepttype_i=8 → stall=0, flush=0, stall_cnt=0 after release.
2. Priority: id=1 alone → stall=000111. Add ex=1 → 001111. Add mem=1 → 011111. 3 stalled cycles → stall_cnt=3.
3. Syscall: excepttype_i=8 with stallreq_from_ex=1, FLUSH_CYCLES=1 → flush=1 for exactly 1 cycle, new_pc=32'h20, stall=0, stall_cnt unchanged. Next cycle ex=1 → stall=001111.
4. Eret with FLUSH_CYCLES=3: excepttype_i=0xe for 1 cycle, cp0_epc_i=32'h00400100 (changed to 0 on cycle 2) → flush high 3 cycles, new_pc=32'h00400100 throughout. A second exception on cycle 2 is ignored.
5. Reset mid-flush (FLUSH_CYCLES=3): rst on flush cycle 2 → flush=0 from the next cycle, FSM in S_RUN.
6. STALL_WDT_EN, WDT_LIMIT=4: stallreq_from_mem held 1 → wdt_fire pulse and flush with new_pc=32'h20 on the 4th consecutive stall cycle. Without the macro → stall=011111 indefinitely, wdt_fire=0.
